bfloat16_dot_sequencer: RTL
===========================

# bfloat16_dot_sequencer

Sequences a variable-length bfloat16 dot product through one 8-lane `bfloat16_mac_tree` and one feedback `bfloat16_adder` accumulator. Each accepted operand beat carries 8 A/B pairs. The MAC tree reduces the beat to a partial sum, and the block accumulates partial sums over `len` beats. It sits between the operand-fetch stream and the result consumer, and owns the only MAC tree instance in its lane.

## Interface

**Parameters**
- `CNT_W`, default 8. Width of the beat-count field; maximum `len` is 2^CNT_W−1.

**Ports**
- `clk` input, 1 bit. Single clock; all state changes on the rising edge.
- `rst_n` input, 1 bit. Asynchronous, active-low reset.
- `start` input, 1 bit. Begin a job. Sampled only in IDLE.
- `len` input, CNT_W bits. Number of 8-pair beats in the job. Latched with `start`.
- `in_valid` input, 1 bit. Operand beat valid.
- `in_ready` output, 1 bit. Block accepts a beat.
- `in_data` input, 256 bits. Sixteen bfloat16 words, word k at bits [16k+15:16k]. Word 2i is A_i and word 2i+1 is B_i; these map to MAC tree inputs in0..in15 in order.
- `res_valid` output, 1 bit. Result valid.
- `res_ready` input, 1 bit. Consumer accepts the result.
- `res_data` output, 16 bits. Accumulated bfloat16 dot product.
- `busy` output, 1 bit. High in any state other than IDLE.

## Operation

**States:** IDLE, RUN, DRAIN, DONE.

**IDLE**
- `in_ready`=0, `res_valid`=0.
- On `start`=1, latch `len` into `remain`, set `acc` to 0x0000, and clear `psum_v`.
- Next state: RUN if `len`≠0, else DONE (result 0x0000).

**RUN**
- `in_ready`=1.
- A beat is accepted when `in_valid`&&`in_ready`. On acceptance:
  - `psum_q` ← MAC tree output for `in_data`; `psum_v` ← 1.
  - `remain` decrements.
- A cycle with no acceptance sets `psum_v` ← 0 (bubble); `acc` is unchanged.
- Acceptance of the beat with `remain`==1 moves the FSM to DRAIN.

**Accumulator**
- Every cycle with `psum_v`=1: `acc` ← `bfloat16_adder(acc, psum_q)`.
- Rounding and special-value behaviour are exactly those of `bfloat16_adder` and `bfloat16_multiplier`. No extra normalisation.

**DRAIN**
- `in_ready`=0. Lasts exactly one cycle, in which the final `psum_q` is folded into `acc`.
- Next state: DONE.

**DONE**
- `res_valid`=1, `res_data`=`acc`, both held stable until `res_ready`=1.
- On handshake: next state IDLE.

**Ignored inputs**
- `start` outside IDLE is ignored.
- `in_valid` outside RUN is ignored (no acceptance).
- `len` is don't-care except in the IDLE cycle where `start` is sampled.

**Reset**
- Asserting `rst_n`=0 at any time, including mid-job, forces IDLE immediately.
- Reset values: `acc`=0x0000, `psum_q`=0x0000, `psum_v`=0, `remain`=0.
- Output reset values: `in_ready`=0, `res_valid`=0, `res_data`=0x0000, `busy`=0.
- A partially accumulated job is discarded; no result is produced for it.

## Timing

**Start to first acceptance**
- `start` seen at edge E0 (IDLE).
- `in_ready` is high from E0 onward; the first beat can be accepted at edge E1.

**Pipeline**
- Beat accepted at edge e: `psum_q` is valid after e, and its contribution is in `acc` after e+1.

**Last beat to result**
- Last beat accepted at edge eL: DRAIN during cycle eL..eL+1.
- `res_valid`=1 from edge eL+1 onward.
- Minimum job time with no stalls: `len`+2 cycles from `start` to `res_valid`.

**`len`=0**
- `start` at E0 gives `res_valid`=1 after E0 with `res_data`=0x0000.

**Back-to-back jobs**
- A new `start` is honoured only in IDLE, which is reached the cycle after the result handshake. The minimum gap is one IDLE cycle between jobs.

**Decisions fixed for this block**
- `in_ready` and `res_valid` are registered outputs: they are state-decoded from flops, with no combinational path from `in_valid` or `res_ready`.
- Both stages of the accumulate pipeline are held in flops.

## Test plan

- **Single beat.** `len`=1, all sixteen words 0x3F80 (1.0), `res_ready`=1 → `res_data`=0x4100 (8.0), `res_valid` rising 3 cycles after `start`.
- **Two beats with a bubble.** `len`=2; beat 0 all 0x3F80; then one cycle of `in_valid`=0; beat 1 has A=0x4000 (2.0) and B=0x3F00 (0.5).
  - Expected: `res_data`=0x4180 (16.0).
  - `acc` is unchanged during the bubble.
- **Zero-length job.** `len`=0 → `res_valid` asserted one cycle after `start`, `res_data`=0x0000, and `in_ready` never rises.
- **Result backpressure.** `res_ready`=0 for 5 cycles in DONE.
  - `res_valid` and `res_data` stay stable throughout.
  - A `start` pulse issued during this window is ignored.
  - After the handshake, the block returns to IDLE and `busy`=0.
- **Reset mid-job.** Pull `rst_n` low after 3 of 5 beats.
  - All outputs take their reset values asynchronously.
  - A fresh `len`=1 job of all 0x3F80 then returns 0x4100, with no residue from the aborted job.
- **Sign and cancellation.** `len`=2; beat 0 all-ones products (+8.0); beat 1 with A=0xBF80 (−1.0) and B=0x3F80 → `res_data`=0x0000.

Source files
------------

// File: rtl/bfloat16_dot_sequencer.sv
// bfloat16_dot_sequencer
//   Variable-length bfloat16 dot product. Each accepted beat carries eight
//   A/B pairs that one 8-lane MAC tree reduces to a partial sum. A feedback
//   adder folds the partial sums into the accumulator over `len` beats.
//
//   Ports
//     clk, rst_n           clock, asynchronous active-low reset
//     start, len           job request (sampled in IDLE) and beat count
//     in_valid/in_ready    operand beat handshake, in_data = 16 bf16 words
//     res_valid/res_ready  result handshake, res_data = bf16 dot product
//     busy                 high whenever the FSM is not in IDLE
//
//   Arithmetic is bfloat16 with round-to-nearest-even. Subnormal inputs and
//   results are flushed to signed zero. Every NaN becomes 0x7FC0.

module bfloat16_multiplier (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [15:0] p_o
);
    logic              sign;
    logic [15:0]       prod;
    logic [7:0]        mant;
    logic              guard;
    logic              sticky;
    logic [8:0]        rnd;
    logic signed [9:0] expo;
    logic              a_inf, b_inf, a_nan, b_nan, a_zero, b_zero;

    always_comb begin
        a_nan  = (a_i[14:7] == 8'hFF) && (a_i[6:0] != 7'd0);
        b_nan  = (b_i[14:7] == 8'hFF) && (b_i[6:0] != 7'd0);
        a_inf  = (a_i[14:7] == 8'hFF) && (a_i[6:0] == 7'd0);
        b_inf  = (b_i[14:7] == 8'hFF) && (b_i[6:0] == 7'd0);
        a_zero = (a_i[14:7] == 8'h00);
        b_zero = (b_i[14:7] == 8'h00);
        sign   = a_i[15] ^ b_i[15];
        prod   = {8'd0, 1'b1, a_i[6:0]} * {8'd0, 1'b1, b_i[6:0]};
        expo   = $signed({2'b00, a_i[14:7]}) + $signed({2'b00, b_i[14:7]}) - 10'sd127;
        mant   = prod[14:7];
        guard  = prod[6];
        sticky = |prod[5:0];
        // Product of two [1,2) significands lands in [1,4).
        if (prod[15]) begin
            mant   = prod[15:8];
            guard  = prod[7];
            sticky = |prod[6:0];
            expo   = expo + 10'sd1;
        end
        rnd = {1'b0, mant} + {8'd0, guard & (sticky | mant[0])};
        if (rnd[8]) begin
            rnd  = rnd >> 1;
            expo = expo + 10'sd1;
        end
        if (a_nan || b_nan) begin
            p_o = 16'h7FC0;
        end else if (a_inf || b_inf) begin
            p_o = (a_zero || b_zero) ? 16'h7FC0 : {sign, 8'hFF, 7'd0};
        end else if (a_zero || b_zero) begin
            p_o = {sign, 15'd0};
        end else if (expo >= 10'sd255) begin
            p_o = {sign, 8'hFF, 7'd0};
        end else if (expo <= 10'sd0) begin
            p_o = {sign, 15'd0};
        end else begin
            p_o = {sign, expo[7:0], rnd[6:0]};
        end
    end
endmodule

module bfloat16_adder (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [15:0] sum_o
);
    logic [15:0]       big, sml;
    logic [7:0]        dexp;
    // Working significand: carry | hidden | 7 fraction | guard, round, sticky
    logic [11:0]       mb, ms, msh, s;
    logic              st_al, found;
    logic [3:0]        lz;
    logic [7:0]        mant;
    logic              guard, sticky;
    logic [8:0]        rnd;
    logic signed [9:0] expo;

    always_comb begin
        if (a_i[14:0] >= b_i[14:0]) begin
            big = a_i;
            sml = b_i;
        end else begin
            big = b_i;
            sml = a_i;
        end
        dexp  = big[14:7] - sml[14:7];
        mb    = {1'b0, 1'b1, big[6:0], 3'b000};
        ms    = {1'b0, 1'b1, sml[6:0], 3'b000};
        st_al = 1'b0;
        for (int i = 0; i < 11; i++) begin
            if (i < int'(dexp)) st_al = st_al | ms[i];
        end
        msh    = (dexp >= 8'd11) ? 12'd0 : (ms >> dexp);
        msh[0] = msh[0] | st_al;
        s      = (big[15] == sml[15]) ? (mb + msh) : (mb - msh);
        expo   = $signed({2'b00, big[14:7]});
        lz     = 4'd0;
        found  = 1'b0;
        if (s[11]) begin
            s    = {1'b0, s[11:2], s[1] | s[0]};
            expo = expo + 10'sd1;
        end else begin
            for (int i = 10; i >= 0; i--) begin
                if (!found && s[i]) begin
                    lz    = 4'(10 - i);
                    found = 1'b1;
                end
            end
            s    = s << lz;
            expo = expo - $signed({6'd0, lz});
        end
        mant   = s[10:3];
        guard  = s[2];
        sticky = |s[1:0];
        rnd    = {1'b0, mant} + {8'd0, guard & (sticky | mant[0])};
        if (rnd[8]) begin
            rnd  = rnd >> 1;
            expo = expo + 10'sd1;
        end

        if (big[14:7] == 8'hFF) begin
            if (big[6:0] != 7'd0)
                sum_o = 16'h7FC0;
            else if (sml[14:7] == 8'hFF && sml[15] != big[15])
                sum_o = 16'h7FC0;
            else
                sum_o = big;
        end else if (big[14:7] == 8'h00) begin
            sum_o = {a_i[15] & b_i[15], 15'd0};
        end else if (sml[14:7] == 8'h00) begin
            sum_o = big;
        end else if (s == 12'd0) begin
            sum_o = 16'h0000;  // exact cancellation yields +0
        end else if (expo >= 10'sd255) begin
            sum_o = {big[15], 8'hFF, 7'd0};
        end else if (expo <= 10'sd0) begin
            sum_o = {big[15], 15'd0};
        end else begin
            sum_o = {big[15], expo[7:0], rnd[6:0]};
        end
    end
endmodule

module bfloat16_mac_tree (
    input  logic [255:0] in_i,
    output logic [15:0]  sum_o
);
    logic [15:0] prod [8];
    logic [15:0] lvl1 [4];
    logic [15:0] lvl2 [2];

    for (genvar i = 0; i < 8; i++) begin : g_mul
        bfloat16_multiplier u_mul (
            .a_i (in_i[32*i +: 16]),
            .b_i (in_i[32*i+16 +: 16]),
            .p_o (prod[i])
        );
    end
    for (genvar j = 0; j < 4; j++) begin : g_l1
        bfloat16_adder u_add (.a_i(prod[2*j]), .b_i(prod[2*j+1]), .sum_o(lvl1[j]));
    end
    for (genvar k = 0; k < 2; k++) begin : g_l2
        bfloat16_adder u_add (.a_i(lvl1[2*k]), .b_i(lvl1[2*k+1]), .sum_o(lvl2[k]));
    end
    bfloat16_adder u_root (.a_i(lvl2[0]), .b_i(lvl2[1]), .sum_o(sum_o));
endmodule

// state | meaning
// IDLE  | waiting for start, no handshakes offered
// RUN   | accepting operand beats, accumulating partial sums
// DRAIN | folding the last partial sum into the accumulator
// DONE  | presenting the result until res_ready
module bfloat16_dot_sequencer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [255:0]     in_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [15:0]      res_data,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] remain_q;
    logic [15:0]      psum_q, acc_q;
    logic             psum_v_q;
    logic             in_ready_q, res_valid_q, busy_q;
    logic [15:0]      psum_d, acc_d;

    bfloat16_mac_tree u_tree (.in_i(in_data), .sum_o(psum_d));
    bfloat16_adder    u_acc  (.a_i(acc_q), .b_i(psum_q), .sum_o(acc_d));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            remain_q    <= '0;
            psum_q      <= 16'h0000;
            psum_v_q    <= 1'b0;
            acc_q       <= 16'h0000;
            in_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            // Second pipeline stage; IDLE overrides it when a job starts.
            if (psum_v_q) acc_q <= acc_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        remain_q <= len;
                        acc_q    <= 16'h0000;
                        psum_v_q <= 1'b0;
                        busy_q   <= 1'b1;
                        if (len != '0) begin
                            state_q    <= RUN;
                            in_ready_q <= 1'b1;
                        end else begin
                            state_q     <= DONE;
                            res_valid_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (in_valid) begin
                        psum_q   <= psum_d;
                        psum_v_q <= 1'b1;
                        remain_q <= remain_q - CNT_W'(1);
                        if (remain_q == CNT_W'(1)) begin
                            state_q    <= DRAIN;
                            in_ready_q <= 1'b0;
                        end
                    end else begin
                        psum_v_q <= 1'b0;
                    end
                end
                DRAIN: begin
                    psum_v_q    <= 1'b0;
                    state_q     <= DONE;
                    res_valid_q <= 1'b1;
                end
                DONE: begin
                    if (res_ready) begin
                        state_q     <= IDLE;
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign res_valid = res_valid_q;
    assign res_data  = acc_q;
    assign busy      = busy_q;
endmodule
